// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream widths, lane-index helper and width-down state type
//
// Purpose : default stream widths, derived ratio / lane-index width, EMPTY/DRAIN state typedef.
// Ports   : none (package).

package axis_pkg;

  localparam int DEF_IN_DWIDTH  = 256;
  localparam int DEF_OUT_DWIDTH = 64;
  localparam int DEF_RATIO      = DEF_IN_DWIDTH / DEF_OUT_DWIDTH;

  // Lane index needs at least one bit even when the ratio is 1.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_RATIO);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } wd_state_e;

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream-like bundle with sink and source views
//
// Purpose : carries tdata/tkeep/tvalid/tlast forward and tready backward.
// Ports   : none; modport sink (data in, tready out), modport source (data out, tready in).

interface axis_if #(
  parameter int DWIDTH = 64
) ();

  logic [DWIDTH-1:0]   tdata;
  logic [DWIDTH/8-1:0] tkeep;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport sink (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );

  modport source (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

endinterface

// File: rtl/axis_width_down.sv
// rtl/axis_width_down.sv - splits one wide stream beat into RATIO narrow beats
//
// Purpose : buffers one wide beat and emits its lanes LSB-first, stopping at the
//           highest lane with any keep bit set (lane 0 for an all-zero keep).
// Ports   : clk     rising-edge clock
//           rst_n   asynchronous active-low reset
//           s_axis  wide sink stream   (IN_DWIDTH)
//           m_axis  narrow source stream (OUT_DWIDTH)

module axis_width_down
  import axis_pkg::*;
#(
  parameter int IN_DWIDTH  = DEF_IN_DWIDTH,
  parameter int OUT_DWIDTH = DEF_OUT_DWIDTH
) (
  input logic    clk,
  input logic    rst_n,
  axis_if.sink   s_axis,
  axis_if.source m_axis
);

  localparam int RATIO  = IN_DWIDTH / OUT_DWIDTH;
  localparam int IDX_W  = idx_width(RATIO);
  localparam int IN_KW  = IN_DWIDTH / 8;
  localparam int OUT_KW = OUT_DWIDTH / 8;

  wd_state_e              state;
  wd_state_e              state_nxt;
  logic [IN_DWIDTH-1:0]   buf_data;
  logic [IN_KW-1:0]       buf_keep;
  logic                   buf_last;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       last_lane;
  logic [IDX_W-1:0]       new_last_lane;

  logic                   m_valid;
  logic                   m_hs;
  logic                   at_last;
  logic                   s_ready;
  logic                   capture;

  // Highest lane whose keep slice has any bit set; stays 0 for all-zero keep
  // so a keep-less beat still produces one narrow beat carrying tlast.
  always_comb begin
    new_last_lane = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (|s_axis.tkeep[i*OUT_KW +: OUT_KW]) begin
        new_last_lane = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Accepting a new beat on the final-lane handshake keeps the narrow side
  // busy every cycle across back-to-back wide beats.
  always_comb begin
    state_nxt = state;
    m_valid   = (state == DRAIN);
    at_last   = (idx == last_lane);
    m_hs      = m_valid && m_axis.tready;
    s_ready   = (state == EMPTY) || (m_hs && at_last);
    capture   = s_axis.tvalid && s_ready;
    case (state)
      EMPTY: begin
        if (capture) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (m_hs && at_last && !capture) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data  <= '0;
      buf_keep  <= '0;
      buf_last  <= 1'b0;
      idx       <= '0;
      last_lane <= '0;
    end else if (capture) begin
      buf_data  <= s_axis.tdata;
      buf_keep  <= s_axis.tkeep;
      buf_last  <= s_axis.tlast;
      idx       <= '0;
      last_lane <= new_last_lane;
    end else if (m_hs && !at_last) begin
      idx <= idx + 1'b1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = buf_data[idx*OUT_DWIDTH +: OUT_DWIDTH];
  assign m_axis.tkeep  = buf_keep[idx*OUT_KW +: OUT_KW];
  assign m_axis.tlast  = m_valid && buf_last && at_last;

endmodule

// File: tb/tb_axis_width_down.sv
// tb/tb_axis_width_down.sv - self-checking bench for axis_width_down

module tb_axis_width_down;

  localparam int IW = 256;
  localparam int OW = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } nb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.DWIDTH(IW)) s_if ();
  axis_if #(.DWIDTH(OW)) m_if ();

  axis_width_down #(.IN_DWIDTH(IW), .OUT_DWIDTH(OW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  nb_t         exp_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          cap_cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          accepted = 1'b0;
  int          rdy_mode = 0;
  int          rdy_phase = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: a wide beat yields lanes 0..L where L is the lane holding the
  // highest set keep bit (0 when keep is empty); tlast only on lane L.
  task automatic model_push(input logic [255:0] d, input logic [31:0] k, input logic l);
    int hb;
    int nl;
    hb = -1;
    for (int b = 0; b < 32; b++) if (k[b]) hb = b;
    nl = (hb < 0) ? 1 : hb / 8 + 1;
    for (int j = 0; j < nl; j++)
      exp_q.push_back('{data: d[j*64 +: 64], keep: k[j*8 +: 8], last: l && (j == nl - 1)});
  endtask

  task automatic monitor();
    nb_t e;
    cyc++;
    chk("m_tvalid", m_if.tvalid, exp_q.size() != 0);
    chk("s_tready", s_if.tready, (exp_q.size() == 0) || (exp_q.size() == 1 && m_if.tready));
    if (prev_stall && m_if.tvalid) begin
      chk("stall_data", m_if.tdata, prev_data);
      chk("stall_keep", m_if.tkeep, prev_keep);
      chk("stall_last", m_if.tlast, prev_last);
    end
    if (m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        chk("m_extra_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("m_tdata", m_if.tdata, e.data);
        chk("m_tkeep", m_if.tkeep, e.keep);
        chk("m_tlast", m_if.tlast, e.last);
      end
      hs_cyc.push_back(cyc);
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_data  = m_if.tdata;
    prev_keep  = m_if.tkeep;
    prev_last  = m_if.tlast;
    accepted = s_if.tvalid && s_if.tready;
    if (accepted) begin
      cap_cyc = cyc;
      model_push(s_if.tdata, s_if.tkeep, s_if.tlast);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: m_if.tready = 1'b1;
      1: m_if.tready = 1'($urandom_range(0, 1));
      2: begin
        m_if.tready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      default: m_if.tready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l);
    int n;
    n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    accepted    = 1'b0;
    do begin
      step();
      n++;
    end while (!accepted && n < 300);
    if (!accepted) chk("s_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tdata  = rand256();
    s_if.tkeep  = $urandom;
    s_if.tlast  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  initial begin
    logic [255:0] d;
    logic [31:0]  k;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 64'h0);
    chk("rst_m_tkeep", m_if.tkeep, 8'h0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_s_tready", s_if.tready, 1'b1);
    step();

    // Full beat, tready held high: four lanes, first one the cycle after capture
    d = {{8{8'h03}}, {8{8'h02}}, {8{8'h01}}, {8{8'h00}}};
    hs_cyc.delete();
    send(d, 32'hFFFF_FFFF, 1'b1);
    idle();
    drain();
    chk("full_count", hs_cyc.size(), 4);
    chk("full_latency", hs_cyc[0], cap_cyc + 1);
    chk("full_span", hs_cyc[3] - hs_cyc[0], 3);

    // Partial beats
    hs_cyc.delete();
    send(rand256(), 32'h0000_FFFF, 1'b1);
    idle();
    drain();
    chk("part2_count", hs_cyc.size(), 2);
    hs_cyc.delete();
    send(rand256(), 32'h0007_FFFF, 1'b1);
    idle();
    drain();
    chk("part3_count", hs_cyc.size(), 3);

    // Backpressure pattern 1,0,0,1,...
    rdy_mode = 2;
    hs_cyc.delete();
    send(rand256(), 32'hFFFF_FFFF, 1'b0);
    send(rand256(), 32'hFFFF_FFFF, 1'b1);
    idle();
    drain();
    chk("bp_count", hs_cyc.size(), 8);

    // Back-to-back at full rate
    rdy_mode = 0;
    m_if.tready = 1'b1;
    step();
    hs_cyc.delete();
    send(rand256(), 32'hFFFF_FFFF, 1'b0);
    send(rand256(), 32'hFFFF_FFFF, 1'b1);
    idle();
    drain();
    chk("b2b_count", hs_cyc.size(), 8);
    chk("b2b_span", hs_cyc[7] - hs_cyc[0], 7);

    // Zero-keep last beat
    hs_cyc.delete();
    send(rand256(), 32'h0, 1'b1);
    idle();
    drain();
    chk("zkeep_count", hs_cyc.size(), 1);

    // Reset in the middle of a drain
    rdy_mode = 3;
    m_if.tready = 1'b0;
    send(rand256(), 32'hFFFF_FFFF, 1'b1);
    idle();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_if.tvalid, 1'b0);
    chk("midrst_tlast", m_if.tlast, 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    m_if.tready = 1'b1;
    repeat (5) step();
    hs_cyc.delete();
    send(rand256(), 32'h00FF_FFFF, 1'b1);
    idle();
    drain();
    chk("postrst_count", hs_cyc.size(), 3);

    // Randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      rdy_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: k = 32'hFFFF_FFFF;
        1: k = 32'h0;
        2: k = $urandom;
        default: k = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      endcase
      send(rand256(), k, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 4)) step();
      end
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
